// File: rtl/elm_layer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : elm_layer_ctrl_if
// Brief    : Bus bundle between the ELM layer controller and its environment.
// Revision : 1.0
// ============================================================================
interface elm_layer_ctrl_if #(
  parameter int DATA_W = 16
);
  localparam int c_CFG_W = 2 * DATA_W + 1;

  logic                start_load;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [DATA_W-1:0]   cfg_data;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                weight_valid;
  logic                bias_valid;
  logic [DATA_W-1:0]   weight_value;
  logic [DATA_W-1:0]   bias_value;
  logic [c_CFG_W-1:0]  config_layer_num;
  logic [c_CFG_W-1:0]  config_neuron_num;
  logic [DATA_W-1:0]   my_input;
  logic                my_input_valid;
  logic                neuron_done;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start_load, cfg_valid, cfg_data, in_valid, in_data, neuron_done,
    input  cfg_ready, in_ready, weight_valid, bias_valid, weight_value, bias_value,
           config_layer_num, config_neuron_num, my_input, my_input_valid,
           busy, done, err
  );

  modport slave (
    input  start_load, cfg_valid, cfg_data, in_valid, in_data, neuron_done,
    output cfg_ready, in_ready, weight_valid, bias_valid, weight_value, bias_value,
           config_layer_num, config_neuron_num, my_input, my_input_valid,
           busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/elm_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elm_layer_ctrl
// Brief    : Loads weights/biases into one ELM layer, then streams features
//            and waits for the neurons to finish, with a WAIT timeout.
// Revision : 1.0
// ============================================================================
module elm_layer_ctrl #(
  parameter int LAYER_NO   = 1,
  parameter int NUM_NEURON = 64,
  parameter int NUM_WEIGHT = 128,
  parameter int DATA_W     = 16,
  parameter int TIMEOUT    = 1024
) (
  input  wire logic       clk,
  input  wire logic       rst,
  elm_layer_ctrl_if.slave bus
);
  localparam int c_CFG_W = 2 * DATA_W + 1;
  localparam int c_WW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int c_NW    = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam int c_TW    = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

  localparam logic [c_WW-1:0]    c_W_LAST = c_WW'(NUM_WEIGHT - 1);
  localparam logic [c_NW-1:0]    c_N_LAST = c_NW'(NUM_NEURON - 1);
  localparam logic [c_TW-1:0]    c_T_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [c_CFG_W-1:0] c_LAYER  = c_CFG_W'(LAYER_NO);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_B = 3'd2,
    S_READY  = 3'd3,
    S_STREAM = 3'd4,
    S_WAIT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t              r_state;
  logic [c_WW-1:0]     r_wcnt;
  logic [c_NW-1:0]     r_ncnt;
  logic [c_WW-1:0]     r_icnt;
  logic [c_TW-1:0]     r_tcnt;
  logic                r_rst_meta;
  logic                r_rst_sync;
  logic                r_weight_valid;
  logic                r_bias_valid;
  logic [DATA_W-1:0]   r_weight_value;
  logic [DATA_W-1:0]   r_bias_value;
  logic [c_CFG_W-1:0]  r_layer_num;
  logic [c_CFG_W-1:0]  r_neuron_num;
  logic [DATA_W-1:0]   r_my_input;
  logic                r_my_input_valid;
  logic                r_done;
  logic                r_err;

  logic w_cfg_ready;
  logic w_in_ready;
  logic w_cfg_hs;
  logic w_in_hs;

  assign w_cfg_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_B);
  assign w_in_ready  = (r_state == S_STREAM);
  assign w_cfg_hs    = bus.cfg_valid & w_cfg_ready;
  assign w_in_hs     = bus.in_valid & w_in_ready;

  // Assertion is immediate; release is re-timed through two flops so the
  // FSM holds off until the third rising edge after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_wcnt           <= '0;
      r_ncnt           <= '0;
      r_icnt           <= '0;
      r_tcnt           <= '0;
      r_weight_valid   <= 1'b0;
      r_bias_valid     <= 1'b0;
      r_weight_value   <= '0;
      r_bias_value     <= '0;
      r_layer_num      <= '0;
      r_neuron_num     <= '0;
      r_my_input       <= '0;
      r_my_input_valid <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
    end else if (!r_rst_sync) begin
      r_weight_valid   <= 1'b0;
      r_bias_valid     <= 1'b0;
      r_my_input_valid <= 1'b0;
      r_done           <= 1'b0;
      case (r_state)
        S_IDLE, S_READY: begin
          if (bus.start_load) begin
            r_state <= S_LOAD_W;
            r_err   <= 1'b0;
            r_wcnt  <= '0;
            r_ncnt  <= '0;
          end else if (r_state == S_READY && bus.in_valid) begin
            r_state <= S_STREAM;
            r_icnt  <= '0;
          end
        end
        S_LOAD_W: begin
          if (w_cfg_hs) begin
            r_weight_value <= bus.cfg_data;
            r_weight_valid <= 1'b1;
            r_neuron_num   <= c_CFG_W'(r_ncnt);
            r_layer_num    <= c_LAYER;
            if (r_wcnt == c_W_LAST) begin
              r_wcnt  <= '0;
              r_state <= S_LOAD_B;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (w_cfg_hs) begin
            r_bias_value <= bus.cfg_data;
            r_bias_valid <= 1'b1;
            r_neuron_num <= c_CFG_W'(r_ncnt);
            r_layer_num  <= c_LAYER;
            if (r_ncnt == c_N_LAST) begin
              r_ncnt  <= '0;
              r_state <= S_READY;
            end else begin
              r_ncnt  <= r_ncnt + 1'b1;
              r_state <= S_LOAD_W;
            end
          end
        end
        S_STREAM: begin
          if (w_in_hs) begin
            r_my_input       <= bus.in_data;
            r_my_input_valid <= 1'b1;
            if (r_icnt == c_W_LAST) begin
              r_icnt  <= '0;
              r_tcnt  <= '0;
              r_state <= S_WAIT;
            end else begin
              r_icnt <= r_icnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          // A completion arriving on the last allowed cycle still wins.
          if (bus.neuron_done) begin
            r_tcnt  <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_tcnt == c_T_LAST) begin
            r_tcnt  <= '0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_READY;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready         = w_cfg_ready;
  assign bus.in_ready          = w_in_ready;
  assign bus.busy              = (r_state != S_IDLE) && (r_state != S_READY);
  assign bus.weight_valid      = r_weight_valid;
  assign bus.bias_valid        = r_bias_valid;
  assign bus.weight_value      = r_weight_value;
  assign bus.bias_value        = r_bias_value;
  assign bus.config_layer_num  = r_layer_num;
  assign bus.config_neuron_num = r_neuron_num;
  assign bus.my_input          = r_my_input;
  assign bus.my_input_valid    = r_my_input_valid;
  assign bus.done              = r_done;
  assign bus.err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_elm_layer_ctrl.sv
`default_nettype none
// Bench for elm_layer_ctrl: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a word/phase-level reference model.
module tb_elm_layer_ctrl;
  localparam int NN = 2, NW = 4, DW = 16, TO = 8, LAYER = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elm_layer_ctrl_if #(.DATA_W(DW)) bus ();

  elm_layer_ctrl #(
    .LAYER_NO(LAYER), .NUM_NEURON(NN), .NUM_WEIGHT(NW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a run of NN*(NW+1) cfg words where every
  // (NW+1)-th word is a bias; a stream is NW accepted features.
  typedef enum int {M_IDLE, M_LOAD, M_READY, M_STREAM, M_WAIT, M_DONE} mphase_t;
  mphase_t m_ph = M_IDLE;
  int m_k, m_j, m_w, m_hold;
  bit m_err;
  bit e_wv, e_bv, e_iv;
  logic [DW-1:0] e_wdata, e_bdata, e_idata;
  int e_n;

  int n_wv, n_bv, n_iv, n_done;
  logic [DW-1:0] bias_log[$];
  int bias_n_log[$];
  logic [DW-1:0] last_in;

  task automatic model_reset();
    m_ph = M_IDLE; m_k = 0; m_j = 0; m_w = 0; m_hold = 2; m_err = 0;
    e_wv = 0; e_bv = 0; e_iv = 0;
  endtask

  task automatic model_step();
    e_wv = 0; e_bv = 0; e_iv = 0;
    if (rst) return;
    if (m_hold > 0) begin m_hold--; return; end
    case (m_ph)
      M_IDLE, M_READY: begin
        if (bus.start_load) begin m_ph = M_LOAD; m_k = 0; m_err = 0; end
        else if (m_ph == M_READY && bus.in_valid) begin m_ph = M_STREAM; m_j = 0; end
      end
      M_LOAD: if (bus.cfg_valid) begin
        e_n = m_k / (NW + 1);
        if ((m_k % (NW + 1)) < NW) begin e_wv = 1; e_wdata = bus.cfg_data; end
        else begin e_bv = 1; e_bdata = bus.cfg_data; end
        m_k++;
        if (m_k == NN * (NW + 1)) m_ph = M_READY;
      end
      M_STREAM: if (bus.in_valid) begin
        e_iv = 1; e_idata = bus.in_data; m_j++;
        if (m_j == NW) begin m_ph = M_WAIT; m_w = 0; end
      end
      M_WAIT: begin
        if (bus.neuron_done) m_ph = M_DONE;
        else begin
          m_w++;
          if (m_w == TO) begin m_err = 1; m_ph = M_IDLE; end
        end
      end
      M_DONE: m_ph = M_READY;
      default: m_ph = M_IDLE;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        chk("rst_wvalue", bus.weight_value, 0);
        chk("rst_bvalue", bus.bias_value, 0);
        chk("rst_input", bus.my_input, 0);
        chk("rst_layer", bus.config_layer_num, 0);
        chk("rst_neuron", bus.config_neuron_num, 0);
      end
      chk("cfg_ready", bus.cfg_ready, m_ph == M_LOAD);
      chk("in_ready", bus.in_ready, m_ph == M_STREAM);
      chk("busy", bus.busy, !(m_ph == M_IDLE || m_ph == M_READY));
      chk("err", bus.err, m_err);
      chk("done", bus.done, m_ph == M_DONE);
      chk("weight_valid", bus.weight_valid, e_wv);
      chk("bias_valid", bus.bias_valid, e_bv);
      chk("my_input_valid", bus.my_input_valid, e_iv);
      if (e_wv) begin
        chk("weight_value", bus.weight_value, e_wdata);
        chk("w_neuron", bus.config_neuron_num, e_n);
        chk("w_layer", bus.config_layer_num, LAYER);
      end
      if (e_bv) begin
        chk("bias_value", bus.bias_value, e_bdata);
        chk("b_neuron", bus.config_neuron_num, e_n);
        chk("b_layer", bus.config_layer_num, LAYER);
      end
      if (e_iv) chk("my_input", bus.my_input, e_idata);
      if (bus.weight_valid) n_wv++;
      if (bus.bias_valid) begin
        n_bv++;
        bias_log.push_back(bus.bias_value);
        bias_n_log.push_back(int'(bus.config_neuron_num));
      end
      if (bus.my_input_valid) begin n_iv++; last_in = bus.my_input; end
      if (bus.done) n_done++;
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_cfg(input logic [DW-1:0] d, input int gap);
    bit hs; int b;
    bus.cfg_valid = 1'b0;
    repeat (gap) tick();
    bus.cfg_valid = 1'b1; bus.cfg_data = d; b = 0;
    do begin @(negedge clk); hs = bus.cfg_ready; tick(); b++; end while (!hs && b < 50);
    chk("cfg_handshake", hs, 1);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_in(input logic [DW-1:0] d, input int gap);
    bit hs; int b;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1; bus.in_data = d; b = 0;
    do begin @(negedge clk); hs = bus.in_ready; tick(); b++; end while (!hs && b < 50);
    chk("in_handshake", hs, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_load = 1'b1; tick(); bus.start_load = 1'b0;
  endtask

  task automatic pulse_done();
    bus.neuron_done = 1'b1; tick(); bus.neuron_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0; repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit loaded;
    logic [DW-1:0] d;
    int dl;
    bus.start_load = 0; bus.cfg_valid = 0; bus.cfg_data = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.neuron_done = 0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_cfg_ready", bus.cfg_ready, 0);

    // Load: 10 back-to-back words
    pulse_start();
    for (int k = 1; k <= 10; k++) send_cfg(DW'(k), 0);
    tick();
    chk("load_weights", n_wv, 8);
    chk("load_biases", n_bv, 2);
    chk("bias0", bias_log[0], 16'h0005);
    chk("bias0_n", bias_n_log[0], 0);
    chk("bias1", bias_log[1], 16'h000A);
    chk("bias1_n", bias_n_log[1], 1);
    chk("model_ready", m_ph == M_READY, 1);

    // Stream with toggling valid, then done on 3rd WAIT cycle
    n_iv = 0;
    for (int i = 0; i < 4; i++) send_in(DW'(16'h0100 + i), 1);
    chk("in_ready_dropped", bus.in_ready, 0);
    chk("wait_busy", bus.busy, 1);
    tick();
    chk("stream_count", n_iv, 4);
    chk("stream_last", last_in, 16'h0103);
    tick();
    n_done = 0;
    pulse_done();
    chk("done_high", bus.done, 1);
    tick();
    chk("done_low", bus.done, 0);
    chk("done_count", n_done, 1);
    chk("back_ready", bus.busy, 0);

    // Second stream without reload; start_load during it and neuron_done in READY ignored
    send_in(16'h0200, 0);
    pulse_start();
    for (int i = 1; i < 4; i++) send_in(DW'(16'h0200 + i), 0);
    chk("second_stream", n_iv, 7);
    pulse_done();
    tick();
    pulse_done();
    tick();
    chk("ignore_cfg_ready", bus.cfg_ready, 0);
    chk("ignore_busy", bus.busy, 0);
    chk("done_count2", n_done, 2);

    // Timeout
    for (int i = 0; i < 4; i++) send_in(DW'(16'h0300 + i), 0);
    repeat (7) tick();
    chk("err_before", bus.err, 0);
    tick();
    chk("err_set", bus.err, 1);
    chk("err_idle", bus.busy, 0);
    pulse_start();
    chk("err_cleared", bus.err, 0);

    // Reset after 3rd weight handshake
    for (int k = 0; k < 3; k++) send_cfg(DW'(16'h0011 + k), 0);
    rst = 1'b1;
    #1;
    chk("async_wvalid", bus.weight_valid, 0);
    chk("async_cfg_ready", bus.cfg_ready, 0);
    chk("async_wvalue", bus.weight_value, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    bias_log.delete(); bias_n_log.delete();
    pulse_start();
    for (int k = 1; k <= 10; k++) send_cfg(DW'(16'h0020 + k), 0);
    tick();
    chk("reload_bias0", bias_log[0], 16'h0025);
    chk("reload_bias0_n", bias_n_log[0], 0);

    // Randomized traffic
    loaded = 1;
    for (int it = 0; it < 12; it++) begin
      if (!loaded || $urandom_range(0, 5) == 0) begin
        pulse_start();
        loaded = 1;
        for (int k = 0; k < NN * (NW + 1); k++) begin
          if ($urandom_range(0, 29) == 0) begin do_reset(); loaded = 0; break; end
          d = DW'($urandom);
          send_cfg(d, $urandom_range(0, 2));
        end
      end
      for (int s = 0; s < 3 && loaded; s++) begin
        for (int i = 0; i < NW; i++) begin
          d = DW'($urandom);
          send_in(d, $urandom_range(0, 2));
          if (i == 0 && $urandom_range(0, 3) == 0) pulse_start();
        end
        dl = $urandom_range(0, 10);
        repeat (dl) tick();
        pulse_done();
        tick();
        if (bus.err) loaded = 0;
        if ($urandom_range(0, 3) == 0) pulse_done();
      end
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
